// File: rtl/hub75_rx_monitor_if.sv
// HUB75 panel-side bundle: the lines a panel driver produces and a panel (or monitor) consumes.
interface hub75_rx_monitor_if;
   logic       sclk;
   logic       lat;
   logic       oe_n;
   logic [3:0] addr;
   logic [5:0] rgb;

   modport master (output sclk, lat, oe_n, addr, rgb);
   modport slave  (input  sclk, lat, oe_n, addr, rgb);
endinterface

// File: rtl/hub75_rx_monitor.sv
// HUB75 receive-side monitor: rebuilds pixels, latched rows and OE on-time and flags protocol errors.
// Optional row/frame statistics are enabled with the HUB75_RX_STATS_EN macro.
module hub75_rx_monitor #(
   parameter int unsigned COLS        = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ON_W        = 16,
   localparam int unsigned CW         = $clog2(COLS),
   localparam int unsigned LW         = CW + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hub75_rx_monitor_if.slave    hub,
   input  logic                 err_clr,
   output logic                 pix_valid,
   output logic [CW-1:0]        pix_col,
   output logic [5:0]           pix_rgb,
   output logic                 row_valid,
   output logic [3:0]           row_num,
   output logic [LW-1:0]        row_len,
   output logic                 on_valid,
   output logic [ON_W-1:0]      on_time,
   output logic                 rx_busy,
   output logic                 err_overrun,
   output logic                 err_short,
   output logic                 err_addr,
   output logic [15:0]          frame_cnt,
   output logic                 err_seq
);

   localparam int unsigned IW = 13;
   // Packed as {sclk, lat, oe_n, addr, rgb}; oe_n idles high so it must reset high.
   localparam logic [IW-1:0] SYNC_RST = {1'b0, 1'b0, 1'b1, 4'h0, 6'h00};
   localparam logic [LW-1:0] COLS_L   = LW'(COLS);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SHIFT   = 2'd1;
   localparam logic [1:0] LATCHED = 2'd2;
   localparam logic [1:0] LIT     = 2'd3;

   logic [IW-1:0] pin_vec;
   logic [IW-1:0] sync_q [SYNC_STAGES];
   logic [IW-1:0] s_vec;
   logic [6:0]    dly_q;

   logic          s_sclk, s_lat, s_oe_n;
   logic [3:0]    s_addr;
   logic [5:0]    s_rgb;
   logic          d_sclk, d_lat, d_oe_n;
   logic [3:0]    d_addr;

   logic          sclk_rise, lat_rise, oe_fall, oe_rise;
   logic          pix_accept, overrun_evt, short_evt, addr_evt;
   logic [LW-1:0] col_cnt_q, col_cnt_d, col_after;
   logic [ON_W-1:0] on_cnt_q, on_cnt_d;
   logic [1:0]    state_q, state_d;

   assign pin_vec = {hub.sclk, hub.lat, hub.oe_n, hub.addr, hub.rgb};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
         dly_q <= SYNC_RST[IW-1:6];
      end else begin
         sync_q[0] <= pin_vec;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         dly_q <= sync_q[SYNC_STAGES-1][IW-1:6];
      end
   end

   assign s_vec  = sync_q[SYNC_STAGES-1];
   assign s_sclk = s_vec[12];
   assign s_lat  = s_vec[11];
   assign s_oe_n = s_vec[10];
   assign s_addr = s_vec[9:6];
   assign s_rgb  = s_vec[5:0];
   assign d_sclk = dly_q[6];
   assign d_lat  = dly_q[5];
   assign d_oe_n = dly_q[4];
   assign d_addr = dly_q[3:0];

   assign sclk_rise = s_sclk & ~d_sclk;
   assign lat_rise  = s_lat & ~d_lat;
   assign oe_fall   = ~s_oe_n & d_oe_n;
   assign oe_rise   = s_oe_n & ~d_oe_n;

   // A coincident sclk/lat rise counts the pixel into row_len before clearing.
   always_comb begin
      pix_accept  = sclk_rise && (col_cnt_q < COLS_L);
      overrun_evt = sclk_rise && (col_cnt_q == COLS_L);
      col_after   = col_cnt_q + LW'(pix_accept);
      short_evt   = lat_rise && (col_after != COLS_L);
      col_cnt_d   = lat_rise ? '0 : col_after;
      addr_evt    = ~s_oe_n && (s_addr != d_addr);
   end

   always_comb begin
      on_cnt_d = on_cnt_q;
      if (oe_rise) begin
         on_cnt_d = '0;
      end else if (!s_oe_n && (on_cnt_q != '1)) begin
         on_cnt_d = on_cnt_q + ON_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sclk_rise) state_d = SHIFT;
         SHIFT:   if (lat_rise) state_d = LATCHED;
         LATCHED: begin
            if (oe_fall)        state_d = LIT;
            else if (sclk_rise) state_d = SHIFT;
         end
         LIT:     if (oe_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign rx_busy = (state_q == SHIFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt_q   <= '0;
         on_cnt_q    <= '0;
         state_q     <= IDLE;
         pix_valid   <= 1'b0;
         pix_col     <= '0;
         pix_rgb     <= '0;
         row_valid   <= 1'b0;
         row_num     <= '0;
         row_len     <= '0;
         on_valid    <= 1'b0;
         on_time     <= '0;
         err_overrun <= 1'b0;
         err_short   <= 1'b0;
         err_addr    <= 1'b0;
      end else begin
         col_cnt_q <= col_cnt_d;
         on_cnt_q  <= on_cnt_d;
         state_q   <= state_d;
         pix_valid <= pix_accept;
         row_valid <= lat_rise;
         on_valid  <= oe_rise;
         if (pix_accept) begin
            pix_col <= col_cnt_q[CW-1:0];
            pix_rgb <= s_rgb;
         end
         if (lat_rise) begin
            row_num <= s_addr;
            row_len <= col_after;
         end
         if (oe_rise) on_time <= on_cnt_q;
         // Sticky flags: a new event wins over a simultaneous clear.
         err_overrun <= (err_overrun & ~err_clr) | overrun_evt;
         err_short   <= (err_short & ~err_clr) | short_evt;
         err_addr    <= (err_addr & ~err_clr) | addr_evt;
      end
   end

`ifdef HUB75_RX_STATS_EN
   logic [15:0] frame_cnt_q;
   logic        err_seq_q;
   logic        seen_q;
   logic [3:0]  prev_row_q;
   logic [3:0]  next_row;

   assign next_row = prev_row_q + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         err_seq_q   <= 1'b0;
         seen_q      <= 1'b0;
         prev_row_q  <= '0;
      end else begin
         err_seq_q <= (err_seq_q & ~err_clr) | (lat_rise && seen_q && (s_addr != next_row));
         if (lat_rise) begin
            if (s_addr == 4'd0) frame_cnt_q <= frame_cnt_q + 16'd1;
            prev_row_q <= s_addr;
            seen_q     <= 1'b1;
         end
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign err_seq   = err_seq_q;
`else
   assign frame_cnt = '0;
   assign err_seq   = 1'b0;
`endif

endmodule

// File: doc/hub75_rx_monitor.md
Name: hub75_rx_monitor

Overview:
- Receive-side counterpart of the HUB75 panel driver: sits where the LED panel would, sampling HUB75 lines (SCLK, LAT, OE_n, ADDR, RGB) in the system clock domain.
- Reconstructs per-pixel shift data, latched rows and per-row OE on-time.
- Flags protocol violations.
- Used as an on-chip loopback checker and as the front end of a chained-panel forwarder.

Parameters:
- COLS, 32, expected pixel clocks per row; must be ≥ 2.
- SYNC_STAGES, 2, synchronizer flops on every HUB75 input; must be ≥ 2.
- ON_W, 16, width of the on-time counter; saturates at 2^ON_W-1.

Ports:
- clk  in  1  system clock; must be ≥ 4× the HUB75 SCLK rate.
- rst_n  in  1  asynchronous, active-low reset.
- hub_sclk  in  1  HUB75 shift clock, asynchronous to clk.
- hub_lat  in  1  HUB75 latch, active high.
- hub_oe_n  in  1  HUB75 output enable, active low.
- hub_addr  in  4  HUB75 row address.
- hub_rgb  in  6  {R1,G1,B1,R2,G2,B2}.
- err_clr  in  1  synchronous clear of all sticky error flags.
- pix_valid  out  1  one-cycle pulse per accepted pixel.
- pix_col  out  log2(COLS)  column index of pix_rgb.
- pix_rgb  out  6  sampled RGB.
- row_valid  out  1  one-cycle pulse per latch.
- row_num  out  4  address captured at latch.
- row_len  out  log2(COLS)+1  pixel clocks seen before latch.
- on_valid  out  1  one-cycle pulse at end of an OE-low period.
- on_time  out  ON_W  clk cycles OE_n was low.
- rx_busy  out  1  high in SHIFT state.
- err_overrun  out  1  sticky: more than COLS SCLK rises before a latch.
- err_short  out  1  sticky: latch with row_len ≠ COLS.
- err_addr  out  1  sticky: hub_addr changed while OE_n low.

Behaviour:
- Reset: all outputs 0; col_cnt = 0; on_cnt = 0; state = IDLE. Synchronizer flops reset to 0, except hub_oe_n sync, which resets to 1.
- Sync and edges:
  - Every input passes SYNC_STAGES flops, then one delay register for edge detection.
  - Edges are detected on sclk rise, lat rise, OE_n fall and OE_n rise.
  - Latency from a pin edge to the output pulse is SYNC_STAGES+1 clk cycles (3 at default).
- Pixel path: on sclk rise with col_cnt < COLS:
  - pix_valid = 1, pix_col = col_cnt, pix_rgb = synced rgb from the same cycle as the edge.
  - col_cnt increments.
- If col_cnt == COLS at an sclk rise: no pix_valid, err_overrun set, col_cnt holds (saturates at COLS).
- Latch: on lat rise:
  - row_valid = 1, row_num = synced addr, row_len = col_cnt; col_cnt cleared.
  - err_short set if row_len ≠ COLS.
- sclk rise and lat rise in the same cycle: the pixel is counted first and included in row_len; col_cnt then becomes 0.
- On-time:
  - on_cnt increments every cycle synced OE_n == 0, saturating.
  - On OE_n rise: on_valid = 1, on_time = on_cnt, on_cnt cleared.
  - While OE_n == 0, any synced addr change sets err_addr.
- State machine (rx_busy = SHIFT):
  - IDLE → SHIFT on sclk rise.
  - SHIFT → LATCHED on lat rise.
  - LATCHED → LIT on OE_n fall; LATCHED → SHIFT on sclk rise.
  - LIT → IDLE on OE_n rise.
  - In LIT, sclk rises are still accepted (next-row preload) but do not change state.
  - A lat rise in any state performs the latch action.
- Sticky errors: cleared only by err_clr or rst_n. If err_clr coincides with a new error event, the flag is set (set wins).
- pix_col, pix_rgb, row_num, row_len and on_time hold their last values between pulses.
- Reset asserted mid-row: everything returns to reset values immediately; partial row data is discarded, with no row_valid.

Optional Feature:
- Macro: HUB75_RX_STATS_EN.
- With the macro defined, two extra outputs are added:
  - frame_cnt [15:0]: increments (wrapping) on each row_valid whose row_num == 0.
  - err_seq (sticky, cleared by err_clr): set when row_num ≠ (previous row_num + 1) mod 16. The first row_valid after reset is exempt.
- Without the macro: both outputs exist but are tied to 0, and no stats logic is synthesized.

Test Plan:
- Normal row: 32 SCLK pulses (RGB = column index), LAT, OE_n low 15000 clk, addr = 5.
  - Expect 32 pix_valid with pix_col 0..31 and matching rgb.
  - Expect row_valid with row_num = 5, row_len = 32, no errors.
  - Expect on_valid with on_time = 15000 ±1.
- Short row: 30 SCLK then LAT → row_len = 30, err_short = 1. Then err_clr → err_short = 0.
- Overrun: 34 SCLK then LAT → exactly 32 pix_valid, err_overrun = 1, row_len = 32.
- Coincident edges: 31st SCLK rise and LAT rise on the same pin cycle → row_len = 31, next row starts with pix_col = 0.
- Address glitch plus saturation: change addr 3→4 while OE_n low for 70000 clk with ON_W = 16 → err_addr = 1, on_time = 65535.
- Reset mid-row: rst_n low after 10 SCLK, release, then 32 SCLK + LAT → row_len = 32, no row_valid before reset release.
- With HUB75_RX_STATS_EN: rows 0..15 twice → frame_cnt = 2, err_seq = 0. Then row 7 after row 2 → err_seq = 1.
